// File: rtl/garo_sample_ctrl_pkg.sv
// Shared definitions for the GARO sample controller.
//   garo_state_e : sequencer states (3-bit encoding)
//   cnt_width()  : width of a counter that must hold a given terminal value
package garo_sample_ctrl_pkg;

   localparam int unsigned STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE   = 3'd0,
      ST_WARMUP = 3'd1,
      ST_SAMPLE = 3'd2,
      ST_OUTPUT = 3'd3,
      ST_FAIL   = 3'd4
   } garo_state_e;

   function automatic int unsigned cnt_width(input int unsigned terminal);
      return $clog2(terminal) + 1;
   endfunction

endpackage

// File: rtl/garo_sample_ctrl_sync_2ff.sv
// Two-flop synchronizer for the asynchronous oscillator bit.
//   clk_i  : destination clock
//   rst_ni : asynchronous active-low reset, flops reset to 0
//   d_i    : asynchronous input
//   q_o    : synchronized output (two clk_i cycles of latency)
module sync_2ff
   import garo_sample_ctrl_pkg::*;
(
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/garo_sample_ctrl.sv
// Sequencer for one Galois ring oscillator entropy source.
// Enables the ring, waits a warm-up period, samples the synchronized raw bit
// every SAMPLE_DIV cycles, packs WORD_W samples (first sample at the MSB) into
// a word handed out over valid/ready, and runs a repetition-count health test
// that shuts the ring down until clr_fail.
//   clk, rst_n  : clock, asynchronous active-low reset
//   en          : level, run/stop the source
//   clr_fail    : pulse, clears a latched health failure (FAIL state only)
//   garo_bit    : raw oscillator output, asynchronous
//   garo_en     : ring enable
//   rnd_word    : assembled word, rnd_valid/rnd_ready handshake
//   busy        : high in WARMUP, SAMPLE, OUTPUT
//   health_fail : high while in FAIL
module garo_sample_ctrl
   import garo_sample_ctrl_pkg::*;
#(
   parameter int unsigned WORD_W     = 32,
   parameter int unsigned WARMUP_CYC = 256,
   parameter int unsigned SAMPLE_DIV = 8,
   parameter int unsigned REP_LIMIT  = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              clr_fail,
   input  logic              garo_bit,
   output logic              garo_en,
   output logic [WORD_W-1:0] rnd_word,
   output logic              rnd_valid,
   input  logic              rnd_ready,
   output logic              busy,
   output logic              health_fail
);

   localparam int unsigned WARM_W = cnt_width(WARMUP_CYC);
   localparam int unsigned DIV_W  = cnt_width(SAMPLE_DIV);
   localparam int unsigned BIT_W  = cnt_width(WORD_W);
   localparam int unsigned REP_W  = cnt_width(REP_LIMIT);

   localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(WARMUP_CYC - 1);
   localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SAMPLE_DIV - 1);
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WORD_W - 1);
   localparam logic [REP_W-1:0]  REP_MAX   = REP_W'(REP_LIMIT);

   garo_state_e state_q, state_d;

   logic [WARM_W-1:0] warm_q, warm_d;
   logic [DIV_W-1:0]  div_q, div_d;
   logic [BIT_W-1:0]  bit_q, bit_d;
   logic [REP_W-1:0]  rep_q, rep_d;
   logic              prev_q, prev_d;
   // Only the WORD_W-1 earlier samples are stored; the completing sample is
   // appended straight from the synchronizer when the word is captured.
   logic [WORD_W-2:0] shift_q, shift_d;
   logic [WORD_W-1:0] word_q, word_d;
   logic              valid_q, valid_d;

   logic              sbit;
   logic              strobe;
   logic [REP_W-1:0]  rep_nxt;
   logic [WORD_W-1:0] shift_nxt;
   logic              rep_hit;
   logic              word_done;

   sync_2ff u_sync (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .d_i    (garo_bit),
      .q_o    (sbit)
   );

   assign strobe    = (state_q == ST_SAMPLE) && (div_q == DIV_LAST);
   // rep_q == 0 marks the first sample after warm-up: no history to compare.
   assign rep_nxt   = ((rep_q == '0) || (sbit != prev_q)) ? REP_W'(1) : rep_q + REP_W'(1);
   assign shift_nxt = {shift_q, sbit};
   assign rep_hit   = strobe && (rep_nxt == REP_MAX);
   assign word_done = strobe && (bit_q == BIT_LAST);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: health failure outranks en=0, which outranks word completion
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (en) state_d = ST_WARMUP;
         end
         ST_WARMUP: begin
            if (!en)                     state_d = ST_IDLE;
            else if (warm_q == WARM_LAST) state_d = ST_SAMPLE;
         end
         ST_SAMPLE: begin
            if (rep_hit)        state_d = ST_FAIL;
            else if (!en)       state_d = ST_IDLE;
            else if (word_done) state_d = ST_OUTPUT;
         end
         ST_OUTPUT: begin
            if (rnd_ready) state_d = en ? ST_SAMPLE : ST_IDLE;
         end
         ST_FAIL: begin
            if (clr_fail) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Outputs decoded from state
   always_comb begin
      garo_en     = 1'b0;
      busy        = 1'b0;
      health_fail = 1'b0;
      case (state_q)
         ST_WARMUP, ST_SAMPLE, ST_OUTPUT: begin
            garo_en = 1'b1;
            busy    = 1'b1;
         end
         ST_FAIL: health_fail = 1'b1;
         default: ;
      endcase
   end

   assign rnd_word  = word_q;
   assign rnd_valid = valid_q;

   // Datapath next-state: counters clear whenever their state is (re)entered
   always_comb begin
      warm_d  = '0;
      div_d   = '0;
      bit_d   = '0;
      rep_d   = rep_q;
      prev_d  = prev_q;
      shift_d = shift_q;
      word_d  = word_q;
      valid_d = valid_q;

      if (state_q == ST_WARMUP && state_d == ST_WARMUP) begin
         warm_d = warm_q + WARM_W'(1);
      end

      if (state_q == ST_SAMPLE && state_d == ST_SAMPLE) begin
         div_d = strobe ? '0 : div_q + DIV_W'(1);
         bit_d = strobe ? bit_q + BIT_W'(1) : bit_q;
      end

      if (state_q == ST_WARMUP) begin
         rep_d = '0;
      end else if (strobe) begin
         rep_d  = rep_nxt;
         prev_d = sbit;
      end

      if (strobe) begin
         shift_d = shift_nxt[WORD_W-2:0];
      end

      if (state_q == ST_SAMPLE && state_d == ST_OUTPUT) begin
         word_d  = shift_nxt;
         valid_d = 1'b1;
      end else if (state_q == ST_OUTPUT && rnd_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         warm_q  <= '0;
         div_q   <= '0;
         bit_q   <= '0;
         rep_q   <= '0;
         prev_q  <= 1'b0;
         shift_q <= '0;
         word_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         warm_q  <= warm_d;
         div_q   <= div_d;
         bit_q   <= bit_d;
         rep_q   <= rep_d;
         prev_q  <= prev_d;
         shift_q <= shift_d;
         word_q  <= word_d;
         valid_q <= valid_d;
      end
   end

endmodule

// File: tb/tb_garo_sample_ctrl.sv
module tb_garo_sample_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en;
   logic       clr_fail;
   logic       garo_bit;
   logic       garo_en;
   logic [7:0] rnd_word;
   logic       rnd_valid;
   logic       rnd_ready;
   logic       busy;
   logic       health_fail;

   int checks    = 0;
   int failures  = 0;
   int valid_cnt = 0;
   int vc0;

   logic [7:0] sb[$];

   always #5 clk = ~clk;

   garo_sample_ctrl #(
      .WORD_W     (8),
      .WARMUP_CYC (4),
      .SAMPLE_DIV (2),
      .REP_LIMIT  (4)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (en),
      .clr_fail    (clr_fail),
      .garo_bit    (garo_bit),
      .garo_en     (garo_en),
      .rnd_word    (rnd_word),
      .rnd_valid   (rnd_valid),
      .rnd_ready   (rnd_ready),
      .busy        (busy),
      .health_fail (health_fail)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: pops the scoreboard on every handshake
   always @(negedge clk) begin
      logic [7:0] e;
      if (rst_n && rnd_valid) valid_cnt++;
      if (rst_n && rnd_valid && rnd_ready) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_word: got %0h expected none", rnd_word);
         end else begin
            e = sb.pop_front();
            chk("word", {24'd0, rnd_word}, {24'd0, e});
         end
      end
   end

   initial begin
      #50000;
      $display("FAIL watchdog: simulation did not finish in time");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1);
   end

   // Called #1 after a posedge with the block in IDLE; the next posedge is
   // WARMUP entry (E0). Bit i is held over edges E(4+2i) and E(5+2i) so the
   // synchronized value is present at strobe i (edge E(6+2i)).
   // Returns at E(3+2n)+1.
   task automatic start_and_feed(input logic [7:0] bits, input int n);
      en = 1'b1;
      chk("garo_en_idle", garo_en, 0);
      @(posedge clk); #1;
      chk("garo_en_warmup", garo_en, 1);
      chk("busy_warmup", busy, 1);
      repeat (3) @(posedge clk);
      #1;
      chk("busy_pre_sample", busy, 1);
      chk("valid_pre_sample", rnd_valid, 0);
      for (int i = 0; i < n; i++) begin
         garo_bit = bits[7-i];
         repeat (2) @(posedge clk);
         #1;
      end
   endtask

   initial begin
      rst_n = 1'b0; en = 1'b0; clr_fail = 1'b0; garo_bit = 1'b0; rnd_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_garo_en", garo_en, 0);
      chk("rst_rnd_word", rnd_word, 0);
      chk("rst_rnd_valid", rnd_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_health_fail", health_fail, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("idle_busy", busy, 0);

      // Alternating bits, ready high: 8'hAA with exactly one valid cycle
      vc0 = valid_cnt;
      sb.push_back(8'hAA);
      start_and_feed(8'hAA, 8);
      chk("aa_not_yet_valid", rnd_valid, 0);
      @(posedge clk); #1;
      chk("aa_valid", rnd_valid, 1);
      chk("aa_word", rnd_word, 8'hAA);
      en = 1'b0;
      @(posedge clk); #1;
      chk("aa_valid_drop", rnd_valid, 0);
      chk("aa_idle_busy", busy, 0);
      chk("aa_idle_garo_en", garo_en, 0);
      chk("aa_one_valid_cycle", valid_cnt - vc0, 1);
      repeat (2) @(posedge clk);
      #1;

      // Ready low for 20 cycles; en dropped in OUTPUT still delivers the word
      rnd_ready = 1'b0;
      sb.push_back(8'hCB);
      start_and_feed(8'hCB, 8);
      @(posedge clk); #1;
      en = 1'b0;
      for (int c = 0; c < 20; c++) begin
         garo_bit = ~garo_bit;
         chk("stall_valid", rnd_valid, 1);
         chk("stall_word", rnd_word, 8'hCB);
         chk("stall_garo_en", garo_en, 1);
         @(posedge clk); #1;
      end
      rnd_ready = 1'b1;
      @(posedge clk); #1;
      chk("stall_valid_drop", rnd_valid, 0);
      chk("stall_idle_busy", busy, 0);
      repeat (2) @(posedge clk);
      #1;

      // Constant 1 -> repetition failure on the 4th strobe
      vc0 = valid_cnt;
      start_and_feed(8'hF0, 4);
      chk("pre_fail_health", health_fail, 0);
      chk("pre_fail_garo_en", garo_en, 1);
      @(posedge clk); #1;
      chk("fail_health", health_fail, 1);
      chk("fail_garo_en", garo_en, 0);
      chk("fail_busy", busy, 0);
      chk("fail_valid", rnd_valid, 0);
      repeat (5) @(posedge clk);
      #1;
      chk("fail_sticky", health_fail, 1);
      clr_fail = 1'b1;
      @(posedge clk); #1;
      clr_fail = 1'b0;
      en = 1'b0;
      chk("clr_health", health_fail, 0);
      chk("clr_busy", busy, 0);
      @(posedge clk); #1;
      chk("clr_idle_garo_en", garo_en, 0);
      chk("fail_no_word", valid_cnt - vc0, 0);

      // en dropped after 3 sampled bits: no word
      vc0 = valid_cnt;
      start_and_feed(8'hA0, 3);
      @(posedge clk); #1;
      en = 1'b0;
      @(posedge clk); #1;
      chk("abort_garo_en", garo_en, 0);
      chk("abort_busy", busy, 0);
      repeat (10) @(posedge clk);
      #1;
      chk("abort_no_word", valid_cnt - vc0, 0);

      // Reset mid-OUTPUT, then a full warm-up before sampling again
      rnd_ready = 1'b0;
      start_and_feed(8'h34, 8);
      @(posedge clk); #1;
      chk("pre_rst_valid", rnd_valid, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_valid", rnd_valid, 0);
      chk("arst_word", rnd_word, 0);
      chk("arst_garo_en", garo_en, 0);
      chk("arst_busy", busy, 0);
      chk("arst_health", health_fail, 0);
      @(posedge clk);
      @(posedge clk); #1;
      rnd_ready = 1'b1;
      rst_n = 1'b1;
      sb.push_back(8'hA5);
      start_and_feed(8'hA5, 8);
      chk("post_rst_not_yet_valid", rnd_valid, 0);
      @(posedge clk); #1;
      chk("post_rst_valid", rnd_valid, 1);
      en = 1'b0;
      @(posedge clk); #1;
      chk("post_rst_valid_drop", rnd_valid, 0);
      chk("post_rst_idle", busy, 0);

      chk("sb_empty", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
